// File: rtl/keypad_pkg.sv
// Shared keypad types and constants.
// Used by the scanner, its bench and the key event queue.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RELEASE
  } press_state_t;

  localparam key_code_t KEY_0    = 4'h0;
  localparam key_code_t KEY_9    = 4'h9;
  localparam key_code_t KEY_A    = 4'hA;
  localparam key_code_t KEY_STAR = 4'hE;
  localparam key_code_t KEY_HASH = 4'hF;

endpackage

// File: rtl/key_event_fifo_if.sv
// Key input plus queue drain handshake bundle.
// The master side is the scanner/consumer; the slave side is the queue.
interface key_event_fifo_if #(
  parameter int DEPTH = 8
);
  import keypad_pkg::*;

  logic                     key_valid;
  key_code_t                key_code;
  logic                     out_ready;
  logic                     clear_ovf;
  logic                     out_valid;
  key_code_t                out_code;
  logic [$clog2(DEPTH):0]   count;
  logic                     key_active;
  logic                     overflow;

  modport master (
    output key_valid, key_code,
    output out_ready, clear_ovf,
    input  out_valid, out_code,
    input  count, key_active, overflow
  );

  modport slave (
    input  key_valid, key_code,
    input  out_ready, clear_ovf,
    output out_valid, out_code,
    output count, key_active, overflow
  );

endinterface

// File: rtl/key_fifo.sv
// Show-ahead synchronous FIFO with a separate occupancy count.
// A push into a full FIFO only lands when a pop frees a slot the same cycle.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_fifo.sv
// One queue entry per physical key press, with release filtering
// against hold and bounce, drained by a ready/valid consumer.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input logic             clock,
  input logic             reset,
  key_event_fifo_if.slave bus
);

  localparam int CW   = $clog2(RELEASE_CYCLES) + 1;
  // The low edge leaving HELD already counts toward the release window.
  localparam int LAST = (RELEASE_CYCLES > 2) ? RELEASE_CYCLES - 2 : 0;

  press_state_t state;
  logic [CW-1:0] rel_cnt;
  logic          push;
  logic          full;
  logic          empty;
  logic          dropped;
  key_code_t     head;

  assign push    = (state == IDLE) && bus.key_valid;
  assign dropped = push && full && !bus.out_ready;

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_CODE_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (bus.key_code),
    .pop   (bus.out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  assign bus.out_valid = !empty;
  assign bus.out_code  = head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rel_cnt        <= '0;
      bus.key_active <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      if (dropped) begin
        bus.overflow <= 1'b1;
      end else if (bus.clear_ovf) begin
        bus.overflow <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.key_valid) begin
            state          <= HELD;
            bus.key_active <= 1'b1;
          end
        end
        HELD: begin
          if (!bus.key_valid) begin
            state   <= RELEASE;
            rel_cnt <= '0;
          end
        end
        RELEASE: begin
          if (bus.key_valid) begin
            state   <= HELD;
            rel_cnt <= '0;
          end else if (rel_cnt == CW'(LAST)) begin
            state          <= IDLE;
            rel_cnt        <= '0;
            bus.key_active <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + CW'(1);
          end
        end
        default: begin
          state          <= IDLE;
          rel_cnt        <= '0;
          bus.key_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo with a scoreboard of expected pops.
// Inputs change just after the falling edge; outputs are sampled there.
module tb_key_event_fifo;
  import keypad_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  logic watch_cnt = 1'b0;
  key_code_t sb[$];

  key_event_fifo_if #(.DEPTH(8)) bus ();

  key_event_fifo #(
    .DEPTH          (8),
    .RELEASE_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    key_code_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $error("FAIL pop_extra observed=%0h expected=none", bus.out_code);
      end else begin
        e = sb.pop_front();
        check("pop_code", 32'(bus.out_code), 32'(e));
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (watch_cnt) check("wrap_count_le1", 32'(bus.count <= 1), 32'(1));
  endtask

  task automatic press(key_code_t c, int hi, int lo);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    repeat (hi) tick();
    bus.key_valid = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic drain(string tag);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    bus.out_ready = 1'b0;
    check({tag, "_sb_left"}, 32'(sb.size()), 32'(0));
    check({tag, "_empty"}, 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.out_ready = 1'b0;
    bus.clear_ovf = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_out_code", 32'(bus.out_code), 32'(0));
    check("rst_key_active", 32'(bus.key_active), 32'(0));
    check("rst_overflow", 32'(bus.overflow), 32'(0));

    // single long press
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    sb.push_back(4'h5);
    tick();
    check("hold_count_1st", 32'(bus.count), 32'(1));
    check("hold_code_1st", 32'(bus.out_code), 32'(5));
    check("hold_active", 32'(bus.key_active), 32'(1));
    repeat (5) tick();
    bus.key_valid = 1'b0;
    repeat (6) tick();
    check("hold_count_end", 32'(bus.count), 32'(1));
    check("hold_inactive", 32'(bus.key_active), 32'(0));
    drain("hold");

    // bounce during release
    bus.key_code  = 4'h3;
    sb.push_back(4'h3);
    bus.key_valid = 1'b1;
    repeat (3) tick();
    bus.key_valid = 1'b0;
    repeat (2) tick();
    bus.key_valid = 1'b1;
    repeat (2) tick();
    bus.key_valid = 1'b0;
    repeat (3) tick();
    check("bounce_active_3low", 32'(bus.key_active), 32'(1));
    tick();
    check("bounce_idle_4low", 32'(bus.key_active), 32'(0));
    repeat (6) tick();
    check("bounce_count", 32'(bus.count), 32'(1));
    drain("bounce");

    // fill, then one dropped press
    for (int j = 0; j < 8; j++) begin
      sb.push_back(4'(j));
      press(4'(j), 2, 6);
    end
    check("fill_count", 32'(bus.count), 32'(8));
    check("fill_ovf_clear", 32'(bus.overflow), 32'(0));
    press(4'hA, 2, 6);
    check("ovf_count", 32'(bus.count), 32'(8));
    check("ovf_set", 32'(bus.overflow), 32'(1));
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    check("ovf_cleared", 32'(bus.overflow), 32'(0));
    drain("fill");

    // push and pop on the same edge while full
    for (int j = 0; j < 8; j++) begin
      sb.push_back(4'(j + 8));
      press(4'(j + 8), 2, 6);
    end
    check("full2_count", 32'(bus.count), 32'(8));
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hC;
    bus.out_ready = 1'b1;
    sb.push_back(4'hC);
    tick();
    bus.out_ready = 1'b0;
    check("simul_count", 32'(bus.count), 32'(8));
    check("simul_ovf", 32'(bus.overflow), 32'(0));
    tick();
    bus.key_valid = 1'b0;
    repeat (6) tick();
    drain("simul");

    // pointer wrap with immediate drain
    bus.out_ready = 1'b1;
    watch_cnt     = 1'b1;
    for (int j = 0; j < 20; j++) begin
      sb.push_back(4'(j % 16));
      press(4'(j % 16), 1, 5);
    end
    watch_cnt = 1'b0;
    drain("wrap");

    // asynchronous reset mid-operation
    for (int j = 0; j < 3; j++) begin
      sb.push_back(4'(j + 1));
      press(4'(j + 1), 2, 6);
    end
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h9;
    repeat (2) tick();
    check("pre_rst_count", 32'(bus.count), 32'(4));
    #1 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'(0));
    check("arst_count", 32'(bus.count), 32'(0));
    check("arst_out_code", 32'(bus.out_code), 32'(0));
    check("arst_key_active", 32'(bus.key_active), 32'(0));
    sb.delete();
    bus.key_code = 4'h6;
    #1 reset = 1'b0;
    sb.push_back(4'h6);
    tick();
    check("post_rst_count", 32'(bus.count), 32'(1));
    check("post_rst_code", 32'(bus.out_code), 32'(6));
    bus.key_valid = 1'b0;
    repeat (6) tick();
    drain("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
# key_event_fifo

Downstream consumer of the hex keypad scanner. It turns the scanner's level-style `valid`/`code` pair into exactly one event per physical key press. A release filter blocks re-triggering while a key is held or bouncing. Accepted key codes are queued in a small FIFO and drained through a ready/valid handshake by the next consumer, such as a command or PIN-entry block.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `RELEASE_CYCLES`, 4: consecutive cycles with `key_valid` low required before a new press is accepted; minimum 1.
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `key_valid`  in  1  scanner valid, already synchronous to `clock`.
- `key_code`  in  4  scanner code; meaningful only while `key_valid`=1.
- `out_ready`  in  1  consumer accepts the head entry this cycle.
- `clear_ovf`  in  1  clears the sticky `overflow` flag.
- `out_valid`  out  1  FIFO not empty.
- `out_code`  out  4  head entry (show-ahead).
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `key_active`  out  1  FSM is not in IDLE (key held or release pending).
- `overflow`  out  1  sticky flag: a press was dropped because the FIFO was full.

## Operation
- The press FSM has three states:
  - IDLE: if `key_valid`=1, issue a push request with `key_code` and go to HELD.
  - HELD: if `key_valid`=0, clear the release counter and go to RELEASE. Otherwise stay; code changes while held are ignored (no push).
  - RELEASE: if `key_valid`=1, return to HELD. This is treated as bounce: no push, counter cleared. Otherwise increment the counter. When the counter reaches `RELEASE_CYCLES`-1 on a low cycle, go to IDLE.
- Push: write `key_code` at the write pointer.
  - If the FIFO is full and no pop occurs in the same cycle, drop the code and set `overflow`=1.
- Pop: when `out_valid`=1 and `out_ready`=1, the read pointer advances. `out_ready` is ignored while empty.
- Simultaneous push and pop:
  - Both occur and `count` is unchanged. This holds when full, so no overflow is flagged.
  - When empty, the pop is ignored and the push lands.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, giving full = (`count`==DEPTH) and empty = (`count`==0).
- `overflow`:
  - Set by a dropped push.
  - Cleared by `clear_ovf`.
  - If both happen in one cycle, set wins.
- `out_code` is the entry at the read pointer. It is held stable until popped and is undefined-but-stable when empty; drive it to 0 after reset.

## Timing
- Reset values: FSM=IDLE, pointers=0, release counter=0, `count`=0, `out_valid`=0, `out_code`=0, `key_active`=0, `overflow`=0.
- Reset asserted mid-press or mid-drain discards FIFO contents immediately. After deassertion, a `key_valid` that is still high is treated as a new press.
- Push latency: if `key_valid` rises and is sampled at edge k in IDLE, the entry is written at edge k and `out_valid`/`count` reflect it after edge k.
- Pop: the handshake at edge k advances the head; the new `out_code` is visible after edge k.
- `key_active` goes to 1 after the edge that leaves IDLE.
- Minimum spacing between accepted presses is 1 (HELD) + `RELEASE_CYCLES` low cycles + 1 IDLE sample edge.
- No combinational path from `key_valid` or `key_code` to any output. `out_valid` does not depend combinationally on `out_ready`.

## Structure
- `keypad_pkg` contains:
  - the state enum: IDLE, HELD, RELEASE;
  - `KEY_CODE_W` = 4;
  - shared code constants, also used by the scanner bench.
- Sub-module `key_fifo`: a synchronous FIFO with push/pop/full/empty/count, parameterised on `DEPTH` and width. The top level holds the FSM, release counter and overflow flag.

## Test plan
- Reset, then hold `key_valid`=1 with `key_code`=4'h5 for 6 cycles and release. Expect exactly one entry: `out_code`=5, `count`=1 one edge after the first sampled high.
- Bounce: high 3 cycles, low 2, high 2, low 10, with `RELEASE_CYCLES`=4. Expect a single entry; `key_active` returns to 0 after 4 consecutive low cycles.
- Fill: 8 separated presses of codes 0..7 with `out_ready`=0, then a 9th press of 4'hA. Expect `count`=8, `overflow`=1, and an in-order drain 0..7 with no A.
- Full plus simultaneous: with the FIFO full and `out_ready`=1 on the push edge of code 4'hC, expect `count` to stay 8, `overflow` to stay 0, and C to be the last drained.
- Pointer wrap: 20 presses of codes j mod 16, each drained immediately. Expect every output equal to the input sequence and `count` never above 1.
- Reset mid-operation: 3 queued entries plus a held key, then assert `reset` asynchronously between edges. Outputs are 0 immediately. After release with `key_valid` still high, one new entry is pushed.
